// File: rtl/fir_tap_sequencer_if.sv
// fir_tap_sequencer_if: sample, coefficient, MAC operand and result bus of the tap sequencer
interface fir_tap_sequencer_if #(parameter int DWIDTH = 16, parameter int AWIDTH = 6);
  logic              frame_start, ovr_clr, mac_vld, mac_clr, y_vld, busy, ovr;
  logic [DWIDTH-1:0] din, coef_data, mac_acc, mac_a, mac_b, y;
  logic [AWIDTH-1:0] coef_addr;
  modport master (output frame_start, ovr_clr, din, coef_data, mac_acc,
                  input  coef_addr, mac_a, mac_b, mac_vld, mac_clr, y, y_vld, busy, ovr);
  modport slave  (input  frame_start, ovr_clr, din, coef_data, mac_acc,
                  output coef_addr, mac_a, mac_b, mac_vld, mac_clr, y, y_vld, busy, ovr);
endinterface

// File: rtl/fir_tap_sequencer.sv
// fir_tap_sequencer: walks all taps per sample, feeds aligned operand pairs to the MAC, captures the sum
module fir_tap_sequencer #(
  parameter int DWIDTH  = 16,
  parameter int AWIDTH  = 6,
  parameter int MAC_LAT = 3
) (
  input logic clk_64x,
  input logic rst_n,
  fir_tap_sequencer_if.slave s
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t            state_q, state_d;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic              start, issue, last, ovr_d;
  logic              s1_vld_q, s1_clr_q, s1_last_q;
  logic              mac_vld_q, mac_clr_q, mac_last_q;
  logic [DWIDTH-1:0] mac_a_q, mac_b_q, y_q;
  logic [MAC_LAT-1:0] tag_q;
  logic              y_vld_q, ovr_q;
  assign start = (state_q == IDLE) & s.frame_start;
  assign issue = start | (state_q == RUN);
  assign last  = (state_q == RUN) & (addr_q == '1);
  always_comb begin
    state_d = start ? RUN : last ? IDLE : state_q;
    addr_d  = issue ? addr_q + 1'b1 : '0;
    ovr_d   = ((state_q == RUN) & s.frame_start) | (ovr_q & ~s.ovr_clr);
  end
  // stage 1 marks the cycle the ROM word and din for a tap are present; the tag then tracks MAC latency
  always_ff @(posedge clk_64x or negedge rst_n)
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      s1_vld_q   <= 1'b0;
      s1_clr_q   <= 1'b0;
      s1_last_q  <= 1'b0;
      mac_vld_q  <= 1'b0;
      mac_clr_q  <= 1'b0;
      mac_last_q <= 1'b0;
      mac_a_q    <= '0;
      mac_b_q    <= '0;
      tag_q      <= '0;
      y_vld_q    <= 1'b0;
      y_q        <= '0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      s1_vld_q   <= issue;
      s1_clr_q   <= start;
      s1_last_q  <= last;
      mac_vld_q  <= s1_vld_q;
      mac_clr_q  <= s1_clr_q;
      mac_last_q <= s1_last_q;
      if (s1_vld_q) begin
        mac_a_q <= s.din;
        mac_b_q <= s.coef_data;
      end
      tag_q      <= MAC_LAT'({tag_q, mac_last_q});
      y_vld_q    <= tag_q[MAC_LAT-1];
      if (tag_q[MAC_LAT-1]) y_q <= s.mac_acc;
      ovr_q      <= ovr_d;
    end
  assign s.coef_addr = addr_q;
  assign s.mac_a     = mac_a_q;
  assign s.mac_b     = mac_b_q;
  assign s.mac_vld   = mac_vld_q;
  assign s.mac_clr   = mac_clr_q;
  assign s.y         = y_q;
  assign s.y_vld     = y_vld_q;
  assign s.ovr       = ovr_q;
  assign s.busy      = (state_q == RUN) | s1_vld_q | mac_vld_q | (|tag_q) | y_vld_q;
endmodule

// File: tb/tb_fir_tap_sequencer.sv
// tb_fir_tap_sequencer: random frames against a frame-level reference model, plus a small-parameter variant
module tb_fir_tap_sequencer;
  localparam int N = 64;
  localparam int L = 3;
  logic clk_64x = 1'b0;
  logic rst_n   = 1'b1;
  always #5 clk_64x = ~clk_64x;
  fir_tap_sequencer_if #(.DWIDTH(16), .AWIDTH(6)) s ();
  fir_tap_sequencer_if #(.DWIDTH(16), .AWIDTH(3)) v ();
  fir_tap_sequencer #(.DWIDTH(16), .AWIDTH(6), .MAC_LAT(L)) dut (.clk_64x(clk_64x), .rst_n(rst_n), .s(s));
  fir_tap_sequencer #(.DWIDTH(16), .AWIDTH(3), .MAC_LAT(1)) dut_v (.clk_64x(clk_64x), .rst_n(rst_n), .s(v));
  int total = 0, bad = 0, cyc = 0, last_t = 0;
  bit have_t = 0, ovr_m = 0, din_fix = 0;
  logic [15:0] rom [0:N-1];
  logic [15:0] din_hist [0:8191];
  int frames [$];
  logic [15:0] hist [$];
  logic [15:0] acc_int = '0, y_hold = '0, a_hold = '0, b_hold = '0;
  logic [5:0] addr_prev = '0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
    end
  endtask
  function automatic logic [15:0] fold(input int t);
    logic [15:0] acc = '0;
    for (int k = 0; k < N; k++) acc = (k == 0) ? 16'(din_hist[t+1+k] * rom[k]) : acc + 16'(din_hist[t+1+k] * rom[k]);
    return acc;
  endfunction
  task automatic step(input bit fs, input bit oc);
    int d;
    bit e_vld, e_clr, e_busy, e_yv, in_run, mv, mc;
    logic [5:0] e_addr;
    logic [15:0] ma, mb;
    s.frame_start = fs;
    s.ovr_clr = oc;
    s.din = din_fix ? 16'h3C00 : 16'($urandom);
    din_hist[cyc] = s.din;
    @(negedge clk_64x);
    e_vld = 0; e_clr = 0; e_busy = 0; e_yv = 0; e_addr = '0;
    foreach (frames[i]) begin
      d = cyc - frames[i];
      if (d >= 0 && d <= N-1) e_addr = 6'(d);
      if (d >= 2 && d <= N+1) begin
        e_vld = 1; e_clr = (d == 2); a_hold = din_hist[cyc-1]; b_hold = rom[d-2];
      end
      if (d >= 1 && d <= N+2+L) e_busy = 1;
      if (d == N+2+L) begin e_yv = 1; y_hold = fold(frames[i]); end
    end
    while (frames.size() > 0 && cyc - frames[0] >= N+2+L) void'(frames.pop_front());
    chk("coef_addr", 32'(s.coef_addr), 32'(e_addr));
    chk("mac_vld", 32'(s.mac_vld), 32'(e_vld));
    chk("mac_clr", 32'(s.mac_clr), 32'(e_clr));
    chk("mac_a", 32'(s.mac_a), 32'(a_hold));
    chk("mac_b", 32'(s.mac_b), 32'(b_hold));
    chk("busy", 32'(s.busy), 32'(e_busy));
    chk("y_vld", 32'(s.y_vld), 32'(e_yv));
    chk("y", 32'(s.y), 32'(y_hold));
    chk("ovr", 32'(s.ovr), 32'(ovr_m));
    in_run = have_t && (cyc - last_t) >= 1 && (cyc - last_t) <= N-1;
    if (rst_n && fs && !in_run) begin frames.push_back(cyc); last_t = cyc; have_t = 1; end
    ovr_m = rst_n && ((fs && in_run) || (ovr_m && !oc));
    addr_prev = s.coef_addr;
    mv = s.mac_vld; mc = s.mac_clr; ma = s.mac_a; mb = s.mac_b;
    @(posedge clk_64x);
    #1;
    cyc++;
    s.coef_data = rom[addr_prev];
    if (mv) acc_int = mc ? 16'(ma * mb) : acc_int + 16'(ma * mb);
    hist.push_back(acc_int);
    if (hist.size() > 8) void'(hist.pop_front());
    s.mac_acc = (hist.size() >= L) ? hist[hist.size()-L] : '0;
  endtask
  task automatic do_reset(input int n);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_coef_addr", 32'(s.coef_addr), 0);
    chk("rst_mac_vld", 32'(s.mac_vld), 0);
    chk("rst_mac_a", 32'(s.mac_a), 0);
    chk("rst_y", 32'(s.y), 0);
    chk("rst_y_vld", 32'(s.y_vld), 0);
    chk("rst_busy", 32'(s.busy), 0);
    chk("rst_ovr", 32'(s.ovr), 0);
    frames.delete();
    have_t = 0; ovr_m = 0; y_hold = '0; a_hold = '0; b_hold = '0;
    repeat (n) step(0, 0);
    rst_n = 1'b1;
  endtask
  initial begin
    s.frame_start = 0; s.ovr_clr = 0; s.din = '0; s.coef_data = '0; s.mac_acc = '0;
    v.frame_start = 0; v.ovr_clr = 0; v.din = '0; v.coef_data = '0; v.mac_acc = '0;
    for (int k = 0; k < N; k++) rom[k] = 16'(k);
    do_reset(3);
    din_fix = 1;
    step(1, 0);
    repeat (80) step(0, 0);
    din_fix = 0;
    for (int k = 0; k < N; k++) rom[k] = 16'($urandom);
    for (int f = 0; f < 3; f++) begin
      step(1, 0);
      repeat (N-1) step(0, 0);
    end
    repeat (20) step(0, 0);
    step(1, 0);
    repeat (29) step(0, 0);
    step(1, 0);
    repeat (9) step(0, 0);
    step(1, 1);
    step(0, 0);
    step(0, 1);
    repeat (80) step(0, 0);
    step(1, 0);
    repeat (39) step(0, 0);
    do_reset(5);
    repeat (5) step(0, 0);
    step(1, 0);
    repeat (100) step(0, 0);
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 499) == 0) do_reset(2);
      step($urandom_range(0, 29) == 0, $urandom_range(0, 9) == 0);
    end
    repeat (N+10) step(0, 0);
    v.frame_start = 1;
    v.mac_acc = 16'hA000;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk_64x);
      chk("var_mac_vld", 32'(v.mac_vld), 32'(c >= 2 && c <= 9));
      chk("var_y_vld", 32'(v.y_vld), 32'(c == 11));
      if (c == 11) chk("var_y", 32'(v.y), 32'h0000A00A);
      @(posedge clk_64x);
      #1;
      v.frame_start = 0;
      v.mac_acc = 16'hA000 + 16'(c + 1);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
